// File: rtl/demux_sched_pkg.sv
// Shared constants and types for the round-robin demux sequencer.
package demux_sched_pkg;

  // Channel count and the select width that addresses those channels.
  localparam int unsigned NCH   = 4;
  localparam int unsigned SEL_W = 2;

  // Target selection modes, as driven on the mode input.
  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // IDLE: buffer empty. BUSY: buffer holds a word waiting for its target.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Next channel in rotation, wrapping 3 -> 0.
  function automatic logic [SEL_W-1:0] next_chan(input logic [SEL_W-1:0] ch);
    return ch + SEL_W'(1);
  endfunction

endpackage

// File: rtl/demux_timeout_timer.sv
// Stall counter for the pending word. It counts cycles while enabled and
// pulses expire during the cycle in which the count reaches TIMEOUT-1. The
// count returns to zero on that cycle's edge so a retargeted word gets a
// fresh window. TIMEOUT=0 disables the expire pulse.
module demux_timeout_timer #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  logic [TW-1:0] count;

  assign expire = (TIMEOUT != 0) && en && (count == LAST);

  // Count stalled cycles; restart on clear or when the window expires.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= expire ? '0 : count + TW'(1);
    end
  end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Sequencer for the 1-to-4 demux: buffers one word from a valid/ready
// producer and presents it to one of four consumers. The target is picked
// round-robin or fixed at capture; a round-robin word that stalls for
// TIMEOUT cycles is moved on to the next channel.
module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel_in,
  output logic [SEL_W-1:0] control,
  output logic [WIDTH-1:0] out_data,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready,
  output logic [CNT_W-1:0] sent_count,
  output logic [CNT_W-1:0] skip_count
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [WIDTH-1:0] data_buf;
  logic             rr_word;    // pending word was captured in round-robin mode

  logic             busy;
  logic             out_fire;
  logic             in_fire;
  logic             expire;
  logic             skip;
  logic [SEL_W-1:0] ptr_next;
  logic [SEL_W-1:0] target;

  assign busy     = (state == BUSY);
  assign out_fire = busy && out_ready[control];
  assign in_ready = !rst && (!busy || out_ready[control]);
  assign in_fire  = in_valid && in_ready;
  assign skip     = expire && rr_word;
  assign out_data = data_buf;

  // Decode the one-hot valid from the current target; silent during reset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    out_valid = '0;
    if (busy && !rst) begin
      out_valid = NCH'(1) << control;
    end
  end

  // Look ahead to the pointer value after this cycle's send so a word
  // captured back-to-back is targeted as if the send had already retired.
  always_comb begin
    ptr_next = ptr;
    if (out_fire && rr_word) begin
      ptr_next = next_chan(control);
    end
    target = (mode == MODE_FIXED) ? sel_in : ptr_next;
  end

  demux_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (in_fire || out_fire || !busy),
    .en     (busy && !out_fire),
    .expire (expire)
  );

  // Buffer/target FSM with the transfer and skip counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      control    <= '0;
      data_buf   <= '0;
      rr_word    <= 1'b0;
      sent_count <= '0;
      skip_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            state <= BUSY;
          end
        end
        BUSY: begin
          if (out_fire) begin
            sent_count <= sent_count + CNT_W'(1);
            ptr        <= ptr_next;
            if (!in_fire) begin
              state <= IDLE;
            end
          end else if (skip) begin
            control <= next_chan(control);
            if (skip_count != '1) begin
              skip_count <= skip_count + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Capture overrides any skip retarget; a capture only happens when the
      // buffer is empty or draining, so the two never meet on a held word.
      if (in_fire) begin
        data_buf <= in_data;
        control  <= target;
        rr_word  <= (mode == MODE_RR);
      end
    end
  end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed bench for demux_rr_scheduler with hand-computed expectations.
module tb_demux_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic [1:0] sel_in;
  logic [1:0] control;
  logic [0:0] out_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] sent_count;
  logic [7:0] skip_count;

  int n_checks = 0;
  int n_fail   = 0;

  demux_rr_scheduler #(
    .WIDTH   (1),
    .TIMEOUT (8),
    .CNT_W   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .sel_in     (sel_in),
    .control    (control),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sent_count (sent_count),
    .skip_count (skip_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream data words back-to-back; each edge sends the previous word and
  // captures the next, whose target follows the rotation table.
  logic [0:0] rr_data [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0] rr_chan [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 1'b1;
    mode = 1'b0; sel_in = 2'd0; out_ready = 4'b0000;

    // Reset held for three edges with a word offered.
    repeat (3) step();
    check("rst_in_ready",  in_ready,   0);
    check("rst_out_valid", out_valid,  0);
    check("rst_control",   control,    0);
    check("rst_sent",      sent_count, 0);
    check("rst_skip",      skip_count, 0);

    // Round-robin streaming, all consumers ready.
    rst = 1'b0; out_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      in_data = rr_data[i];
      #1;
      check($sformatf("rr_in_ready_%0d", i), in_ready, 1);
      step();
      check($sformatf("rr_control_%0d", i), control, rr_chan[i]);
      check($sformatf("rr_data_%0d", i),    out_data, rr_data[i]);
      check($sformatf("rr_valid_%0d", i),   out_valid, 4'b0001 << rr_chan[i]);
      check($sformatf("rr_sent_%0d", i),    sent_count, i);
    end
    in_valid = 1'b0;
    step();
    check("rr_sent_final", sent_count, 5);
    check("rr_idle_valid", out_valid,  0);

    // Fixed mode to channel 2; the rotation pointer (now 1) must not move.
    mode = 1'b1; sel_in = 2'd2; in_valid = 1'b1; in_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("fx_valid_%0d", i),   out_valid, 4'b0100);
      check($sformatf("fx_control_%0d", i), control, 2);
    end
    in_valid = 1'b0;
    step();
    check("fx_sent", sent_count, 8);

    // Timeout skip: next round-robin word lands on channel 1, which stalls.
    mode = 1'b0; out_ready = 4'b1101; in_valid = 1'b1; in_data = 1'b1;
    step();
    check("to_ptr_kept", control, 1);
    in_valid = 1'b0;
    repeat (7) step();
    check("to_hold_control", control,    1);
    check("to_hold_skip",    skip_count, 0);
    step();
    check("to_skip_control", control,    2);
    check("to_skip_count",   skip_count, 1);
    check("to_skip_valid",   out_valid,  4'b0100);
    in_valid = 1'b1; in_data = 1'b0;
    step();
    check("to_sent",         sent_count, 9);
    check("to_next_target",  control,    3);
    in_valid = 1'b0;
    step();
    check("to_next_sent",    sent_count, 10);

    // Fixed-mode stall on channel 3, with mode/sel/data churned while held.
    mode = 1'b1; sel_in = 2'd3; out_ready = 4'b0111; in_valid = 1'b1; in_data = 1'b1;
    step();
    mode = 1'b0; sel_in = 2'd0; in_data = 1'b0;
    repeat (20) step();
    check("fs_control",  control,    3);
    check("fs_data",     out_data,   1);
    check("fs_valid",    out_valid,  4'b1000);
    check("fs_skip",     skip_count, 1);
    check("fs_in_ready", in_ready,   0);
    in_valid = 1'b0; out_ready = 4'b1111;
    step();
    check("fs_sent",     sent_count, 11);
    check("fs_idle",     out_valid,  0);

    // Reset while a word is pending.
    out_ready = 4'b0000; in_valid = 1'b1; in_data = 1'b1;
    step();
    check("mr_busy_valid", out_valid, 4'b0001);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    check("mr_comb_valid", out_valid, 0);
    check("mr_comb_ready", in_ready,  0);
    step();
    rst = 1'b0;
    #1;
    check("mr_valid",   out_valid,  0);
    check("mr_sent",    sent_count, 0);
    check("mr_skip",    skip_count, 1'b0);
    check("mr_control", control,    0);
    check("mr_ready",   in_ready,   1);

    // Sent counter wraps 255 -> 0 during continuous streaming.
    out_ready = 4'b1111; in_valid = 1'b1;
    repeat (256) step();
    check("wrap_255", sent_count, 255);
    step();
    check("wrap_0",   sent_count, 0);
    in_valid = 1'b0;
    step();

    // Skip counter saturates: 256 expiries of a never-accepted word.
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 4'b0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (8 * 256) step();
    check("sat_skip",    skip_count, 255);
    check("sat_control", control,    0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
